clock_btn_ctrl: RTL and testbench

Button front-end for the digital alarm clock: turns raw, bouncy push-button levels into the clean mode levels (Timeset, Alarmset, Alarmon) and single-cycle advance pulses (Minadv, Hrsadv, Dayadv) that the clock core's counters consume as enables. It is the initiator side of the clock core's button interface. It sits between the board pins and the clock core and runs on the same clock as the core's counters.

---
 rtl/clock_ui_pkg.sv | 15 +
 rtl/clock_btn_ctrl_if.sv | 14 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/clock_btn_ctrl.sv | 115 +++++++++++
 tb/tb_clock_btn_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/clock_ui_pkg.sv
// Shared types and default timing constants for the alarm-clock button front-end.
package clock_ui_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TSET = 2'd1,
    ASET = 2'd2
  } mode_t;

  localparam int unsigned DB_DEF      = 4;
  localparam int unsigned HOLD_DEF    = 8;
  localparam int unsigned RPT_DEF     = 2;
  localparam int unsigned IDLE_TO_DEF = 32;

endpackage

// File: rtl/clock_btn_ctrl_if.sv
// Button-side interface into the clock core: mode levels and advance enables.
interface clock_btn_ctrl_if;

  logic Timeset;
  logic Alarmset;
  logic Minadv;
  logic Hrsadv;
  logic Dayadv;
  logic Alarmon;

  modport master (output Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon);
  modport slave  (input  Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon);

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-count debouncer and registered rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DB = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DB + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Level flips once the synchronized input has disagreed long enough; press marks a 0->1 flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB)) begin
        level <= s2;
        press <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_btn_ctrl.sv
// Button front-end: debounces raw buttons, runs the RUN/TSET/ASET mode FSM,
// and generates per-button advance pulses with hold-to-repeat.
module clock_btn_ctrl
  import clock_ui_pkg::*;
#(
  parameter int unsigned DB      = DB_DEF,
  parameter int unsigned HOLD    = HOLD_DEF,
  parameter int unsigned RPT     = RPT_DEF,
  parameter int unsigned IDLE_TO = IDLE_TO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_min,
  input  logic btn_hrs,
  input  logic btn_day,
  input  logic btn_alm,
  clock_btn_ctrl_if.master core
);

  localparam int unsigned RW = $clog2(((HOLD > RPT) ? HOLD : RPT) + 1);
  localparam int unsigned IW = $clog2(IDLE_TO + 1);

  logic          mode_lvl, mode_press;
  logic          alm_lvl, alm_press;
  logic [2:0]    adv_lvl, adv_press;   // index 0 = min, 1 = hrs, 2 = day

  mode_t         state, state_nxt;
  logic [IW-1:0] idle_cnt;
  logic [2:0]    rpt_act, rpt_first;
  logic [RW-1:0] rpt_cnt [3];

  logic          any_lvl, timeout, sup;
  logic [2:0]    allow, due, fire;

  btn_debounce #(.DB(DB)) u_db_mode (.clk(clk), .rst(rst), .raw(btn_mode), .level(mode_lvl),   .press(mode_press));
  btn_debounce #(.DB(DB)) u_db_min  (.clk(clk), .rst(rst), .raw(btn_min),  .level(adv_lvl[0]), .press(adv_press[0]));
  btn_debounce #(.DB(DB)) u_db_hrs  (.clk(clk), .rst(rst), .raw(btn_hrs),  .level(adv_lvl[1]), .press(adv_press[1]));
  btn_debounce #(.DB(DB)) u_db_day  (.clk(clk), .rst(rst), .raw(btn_day),  .level(adv_lvl[2]), .press(adv_press[2]));
  btn_debounce #(.DB(DB)) u_db_alm  (.clk(clk), .rst(rst), .raw(btn_alm),  .level(alm_lvl),    .press(alm_press));

  assign any_lvl = mode_lvl | alm_lvl | (|adv_lvl);
  assign timeout = (state != RUN) && (idle_cnt == IW'(IDLE_TO));
  // Any mode transition silences advance pulses and drops repeat state.
  assign sup     = mode_press | timeout;

  always_comb begin
    state_nxt = state;
    if (mode_press) begin
      case (state)
        RUN:     state_nxt = TSET;
        TSET:    state_nxt = ASET;
        default: state_nxt = RUN;
      endcase
    end else if (timeout) begin
      state_nxt = RUN;
    end
  end

  always_comb begin
    case (state)
      TSET:    allow = 3'b111;
      ASET:    allow = 3'b011;
      default: allow = 3'b000;
    endcase
    for (int i = 0; i < 3; i++) begin
      due[i] = rpt_act[i] && adv_lvl[i] &&
               (rpt_cnt[i] == (rpt_first[i] ? RW'(HOLD) : RW'(RPT)));
    end
    fire = sup ? 3'b000 : (allow & (adv_press | due));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      idle_cnt      <= '0;
      rpt_act       <= '0;
      rpt_first     <= '0;
      for (int i = 0; i < 3; i++) rpt_cnt[i] <= '0;
      core.Timeset  <= 1'b0;
      core.Alarmset <= 1'b0;
      core.Minadv   <= 1'b0;
      core.Hrsadv   <= 1'b0;
      core.Dayadv   <= 1'b0;
      core.Alarmon  <= 1'b0;
    end else begin
      state         <= state_nxt;
      core.Timeset  <= (state_nxt == TSET);
      core.Alarmset <= (state_nxt == ASET);
      core.Minadv   <= fire[0];
      core.Hrsadv   <= fire[1];
      core.Dayadv   <= fire[2];
      if (alm_press) core.Alarmon <= ~core.Alarmon;

      if (state_nxt == RUN || any_lvl) idle_cnt <= '0;
      else if (idle_cnt != IW'(IDLE_TO)) idle_cnt <= idle_cnt + IW'(1);

      // Per-button repeat: count from the last pulse; first interval HOLD, then RPT.
      for (int i = 0; i < 3; i++) begin
        if (sup || !adv_lvl[i]) begin
          rpt_act[i]   <= 1'b0;
          rpt_first[i] <= 1'b0;
          rpt_cnt[i]   <= '0;
        end else if (fire[i]) begin
          rpt_act[i]   <= 1'b1;
          rpt_first[i] <= adv_press[i];
          rpt_cnt[i]   <= RW'(1);
        end else if (rpt_act[i] && rpt_cnt[i] != '1) begin
          rpt_cnt[i]   <= rpt_cnt[i] + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_btn_ctrl.sv
// Self-checking bench for clock_btn_ctrl: level vector table plus a pulse scoreboard.
module tb_clock_btn_ctrl;
  import clock_ui_pkg::*;

  logic clk = 1'b0;
  logic rst, btn_mode, btn_min, btn_hrs, btn_day, btn_alm;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  clock_btn_ctrl_if bus();

  clock_btn_ctrl u_dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_min(btn_min), .btn_hrs(btn_hrs),
    .btn_day(btn_day), .btn_alm(btn_alm),
    .core(bus)
  );

  always #5 clk = ~clk;

  // Pulse scoreboard: {Minadv,Hrsadv,Dayadv} expected at a cycle; all other cycles expect 0.
  typedef struct { int cyc; logic [2:0] p; } pulse_t;
  pulse_t pq[$];
  // Level vectors: btn = {mode,min,hrs,day,alm}, lv = {Timeset,Alarmset,Alarmon}.
  typedef struct { logic [4:0] btn; int hold; logic [2:0] lv; } vec_t;
  logic [2:0] lvq[$];
  vec_t tbl[15];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    pulse_t     e;
    logic [2:0] ep;
    @(posedge clk);
    cyc++;
    #1;
    ep = 3'b000;
    if (pq.size() > 0 && pq[0].cyc == cyc) begin
      e  = pq.pop_front();
      ep = e.p;
    end
    check("pulses", 8'({bus.Minadv, bus.Hrsadv, bus.Dayadv}), 8'(ep));
    check("mode_excl", 8'(bus.Timeset & bus.Alarmset), 8'(0));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_btn(input logic [4:0] b);
    {btn_mode, btn_min, btn_hrs, btn_day, btn_alm} = b;
  endtask

  task automatic check_lv(input string nm, input logic [2:0] e);
    check(nm, 8'({bus.Timeset, bus.Alarmset, bus.Alarmon}), 8'(e));
  endtask

  task automatic push(input int c, input logic [2:0] p);
    pulse_t e;
    e.cyc = c;
    e.p   = p;
    pq.push_back(e);
  endtask

  initial begin
    logic [2:0] lv;
    int c;

    tbl[0]  = '{5'b00000, 50, 3'b000};  // idle after reset
    tbl[1]  = '{5'b10000,  7, 3'b000};  // one cycle before press latency
    tbl[2]  = '{5'b10000,  1, 3'b100};  // TSET at k+7
    tbl[3]  = '{5'b00000, 20, 3'b100};
    tbl[4]  = '{5'b10000,  8, 3'b010};  // ASET
    tbl[5]  = '{5'b00000, 20, 3'b010};
    tbl[6]  = '{5'b10000,  8, 3'b000};  // back to RUN
    tbl[7]  = '{5'b00000, 20, 3'b000};
    tbl[8]  = '{5'b00001,  8, 3'b001};  // alarm on
    tbl[9]  = '{5'b00000, 20, 3'b001};
    tbl[10] = '{5'b00001,  8, 3'b000};  // alarm off
    tbl[11] = '{5'b00000, 20, 3'b000};
    tbl[12] = '{5'b10000,  8, 3'b100};  // TSET again
    tbl[13] = '{5'b00000, 39, 3'b100};  // 32 idle cycles not yet acted on
    tbl[14] = '{5'b00000,  1, 3'b000};  // idle timeout returns to RUN

    rst = 1'b1;
    set_btn(5'b00000);
    ticks(3);
    rst = 1'b0;
    check_lv("reset_levels", 3'b000);

    for (int i = 0; i < 15; i++) begin
      set_btn(tbl[i].btn);
      lvq.push_back(tbl[i].lv);
      ticks(tbl[i].hold);
      lv = lvq.pop_front();
      check_lv($sformatf("vec%0d", i), lv);
    end

    // Bounce then hold min in TSET: first pulse, HOLD gap, then RPT spacing until release.
    set_btn(5'b10000); ticks(8);
    check_lv("enter_tset", 3'b100);
    set_btn(5'b00000); ticks(8);
    for (int i = 0; i < 20; i++) begin
      set_btn((i % 2 == 0) ? 5'b01000 : 5'b00000);
      tick();
    end
    set_btn(5'b01000);
    c = cyc;
    push(c + 8, 3'b100);
    for (int t = c + 16; t <= c + 36; t += 2) push(t, 3'b100);
    ticks(30);
    set_btn(5'b00000); ticks(10);
    check("repeat_queue", 8'(pq.size()), 8'(0));

    // ASET: day ignored, hrs gives a single pulse.
    set_btn(5'b10000); ticks(8);
    check_lv("enter_aset", 3'b010);
    set_btn(5'b00000); ticks(8);
    set_btn(5'b00010); ticks(12);
    set_btn(5'b00000); ticks(8);
    set_btn(5'b00100);
    push(cyc + 8, 3'b010);
    ticks(8);
    set_btn(5'b00000); ticks(10);
    check("aset_queue", 8'(pq.size()), 8'(0));

    // ASET -> RUN -> TSET, then mode and hrs together: mode wins, no hrs pulse while held.
    set_btn(5'b10000); ticks(8);
    check_lv("aset_to_run", 3'b000);
    set_btn(5'b00000); ticks(8);
    set_btn(5'b10000); ticks(8);
    check_lv("run_to_tset", 3'b100);
    set_btn(5'b00000); ticks(8);
    set_btn(5'b10100); ticks(20);
    check_lv("mode_wins", 3'b010);
    set_btn(5'b00000); ticks(10);

    // Back to TSET; min and day pressed together pulse in the same cycle.
    set_btn(5'b10000); ticks(8);
    set_btn(5'b00000); ticks(8);
    set_btn(5'b10000); ticks(8);
    check_lv("tset_again", 3'b100);
    set_btn(5'b00000); ticks(8);
    set_btn(5'b01010);
    push(cyc + 8, 3'b101);
    ticks(8);
    set_btn(5'b00000); ticks(10);
    check("simul_queue", 8'(pq.size()), 8'(0));

    // Reset while alm held: full press latency restarts after reset.
    set_btn(5'b00001); ticks(10);
    check_lv("alm_in_tset", 3'b101);
    rst = 1'b1; tick(); rst = 1'b0;
    check_lv("mid_reset", 3'b000);
    ticks(7);
    check_lv("post_reset_wait", 3'b000);
    tick();
    check_lv("post_reset_press", 3'b001);
    set_btn(5'b00000); ticks(10);
    check("final_queue", 8'(pq.size()), 8'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
